fifo_bank_avalon: RTL and testbench

FIFO_BANK_AVALON -- requirements
Module: fifo_bank_avalon

---
 rtl/fifo_bank_pkg.sv | 24 ++
 rtl/fifo_bank_avalon_if.sv | 30 +++
 rtl/fifo_bank_avalon_sync_fifo.sv | 72 +++++++
 rtl/fifo_bank_avalon.sv | 99 +++++++++
 tb/tb_fifo_bank_avalon.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_bank_pkg.sv
// Shared address map and status-word layout for the fifo_bank_avalon channel FIFO bank.
// Optional overflow counter at ADDR_OVF exists only when FIFO_BANK_OVF_COUNT_EN is defined.
package fifo_bank_pkg;

    localparam logic [3:0] ADDR_CTRL = 4'd0;
    localparam logic [3:0] ADDR_OVF  = 4'd15;

    // Status word returned at ADDR_CTRL: one bit per channel, up to 8 channels.
    typedef struct packed {
        logic [7:0] rsvd_hi;
        logic [7:0] full;
        logic [7:0] rsvd_lo;
        logic [7:0] empty;
    } status_t;

    function automatic logic [31:0] status_word(input logic [7:0] full, input logic [7:0] empty);
        status_t s;
        s       = '0;
        s.full  = full;
        s.empty = empty;
        return s;
    endfunction

endpackage

// File: rtl/fifo_bank_avalon_if.sv
// Avalon-MM slave bus plus per-channel dequeue handshake of the fifo_bank_avalon FIFO bank.
// Bus/handshake is unaffected by FIFO_BANK_OVF_COUNT_EN.
interface fifo_bank_avalon_if #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 32
);
    logic                       chipselect;
    logic                       write;
    logic                       read;
    logic [3:0]                 address;
    logic [31:0]                writedata;
    logic [31:0]                readdata;
    // deq_valid[k] means deq_data for channel k holds the oldest entry; an entry is
    // consumed on a rising edge where deq_valid[k] && deq_ready[k]. deq_ready alone
    // has no effect, and deq_valid never depends on deq_ready.
    logic [NUM_CH-1:0]          deq_valid;
    logic [NUM_CH-1:0]          deq_ready;
    logic [NUM_CH*DATA_W-1:0]   deq_data;

    modport master (
        output chipselect, write, read, address, writedata, deq_ready,
        input  readdata, deq_valid, deq_data
    );

    modport slave (
        input  chipselect, write, read, address, writedata, deq_ready,
        output readdata, deq_valid, deq_data
    );

endinterface

// File: rtl/fifo_bank_avalon_sync_fifo.sv
// Single-clock show-ahead FIFO used once per channel of fifo_bank_avalon.
// Independent of FIFO_BANK_OVF_COUNT_EN.
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A push into a full FIFO is still accepted when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale entries stay hidden behind count_q == 0.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/fifo_bank_avalon.sv
// Bank of NUM_CH show-ahead FIFOs filled over an Avalon-MM slave and drained per channel.
// Define FIFO_BANK_OVF_COUNT_EN to build the saturating dropped-push counter at ADDR_OVF.
module fifo_bank_avalon
    import fifo_bank_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     chipselect,
    input  logic                     write,
    input  logic                     read,
    input  logic [3:0]               address,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    output logic [NUM_CH-1:0]        deq_valid,
    input  logic [NUM_CH-1:0]        deq_ready,
    output logic [NUM_CH*DATA_W-1:0] deq_data
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              wr_en, rd_en;
    logic [NUM_CH-1:0] push, flush, empty, full;
    logic [CW-1:0]     count_w [NUM_CH];
    logic [31:0]       readdata_q, readdata_d;
    logic [7:0]        full8, empty8;

    assign wr_en = chipselect && write;
    assign rd_en = chipselect && read;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign push[k]  = wr_en && (address == 4'(k + 1));
        assign flush[k] = wr_en && (address == ADDR_CTRL) && writedata[k];

        sync_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk    (clk),
            .reset  (reset),
            .push   (push[k]),
            .pop    (deq_ready[k]),
            .flush  (flush[k]),
            .din    (writedata[DATA_W-1:0]),
            .dout   (deq_data[k*DATA_W +: DATA_W]),
            .empty  (empty[k]),
            .full   (full[k]),
            .count  (count_w[k])
        );
    end

    assign deq_valid = ~empty;
    assign readdata  = readdata_q;

`ifdef FIFO_BANK_OVF_COUNT_EN
    logic [15:0] ovf_q, ovf_d;
    logic        drop;

    // At most one channel is addressed per cycle, so at most one drop per edge.
    assign drop = |(push & full & ~(deq_ready & ~empty));

    always_comb begin
        ovf_d = ovf_q;
        if (wr_en && (address == ADDR_CTRL) && writedata[31]) ovf_d = '0;
        else if (drop && (ovf_q != 16'hFFFF))                 ovf_d = ovf_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ovf_q <= '0;
        else        ovf_q <= ovf_d;
    end
`endif

    always_comb begin
        full8                = '0;
        empty8               = '0;
        full8[NUM_CH-1:0]    = full;
        empty8[NUM_CH-1:0]   = empty;
        readdata_d           = readdata_q;
        if (rd_en) begin
            readdata_d = '0;
            if (address == ADDR_CTRL) readdata_d = status_word(full8, empty8);
            for (int k = 0; k < NUM_CH; k++) begin
                if (address == 4'(k + 1)) readdata_d = 32'(count_w[k]);
            end
`ifdef FIFO_BANK_OVF_COUNT_EN
            if (address == ADDR_OVF) readdata_d = {16'h0000, ovf_q};
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) readdata_q <= '0;
        else        readdata_q <= readdata_d;
    end

endmodule

// File: tb/tb_fifo_bank_avalon.sv
// Directed scoreboard bench for fifo_bank_avalon (NUM_CH=3, DATA_W=32, DEPTH=4).
// Overflow expectations follow FIFO_BANK_OVF_COUNT_EN.
module tb_fifo_bank_avalon;

    localparam int NUM_CH = 3;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
`ifdef FIFO_BANK_OVF_COUNT_EN
    localparam logic [31:0] OVF_EXP = 32'd1;
`else
    localparam logic [31:0] OVF_EXP = 32'd0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;

    fifo_bank_avalon_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    fifo_bank_avalon #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (bus.chipselect),
        .write      (bus.write),
        .read       (bus.read),
        .address    (bus.address),
        .writedata  (bus.writedata),
        .readdata   (bus.readdata),
        .deq_valid  (bus.deq_valid),
        .deq_ready  (bus.deq_ready),
        .deq_data   (bus.deq_data)
    );

    always #5 clk = ~clk;

    // Scoreboard state
    logic [31:0] rd_exp_q[$];
    logic [31:0] ch0_q[$];
    logic [31:0] ch1_q[$];
    logic [31:0] ch2_q[$];
    logic        rd_pend = 1'b0;
    int          n_cmp   = 0;
    int          n_err   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic exp_push(input int ch, input logic [31:0] v);
        case (ch)
            0:       ch0_q.push_back(v);
            1:       ch1_q.push_back(v);
            default: ch2_q.push_back(v);
        endcase
    endtask

    function automatic int qsize(input int ch);
        case (ch)
            0:       return ch0_q.size();
            1:       return ch1_q.size();
            default: return ch2_q.size();
        endcase
    endfunction

    function automatic logic [31:0] qpop(input int ch);
        case (ch)
            0:       return ch0_q.pop_front();
            1:       return ch1_q.pop_front();
            default: return ch2_q.pop_front();
        endcase
    endfunction

    // Monitor: samples mid-low-phase, after inputs settle and before the next rising edge.
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            rd_pend = 1'b0;
        end else begin
            if (rd_pend) begin
                if (rd_exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL readdata: got 0x%08h with no expected value queued", bus.readdata);
                end else begin
                    chk("readdata", bus.readdata, rd_exp_q.pop_front());
                end
            end
            rd_pend = bus.chipselect && bus.read;
            for (int k = 0; k < NUM_CH; k++) begin
                if (bus.deq_valid[k] && bus.deq_ready[k]) begin
                    if (qsize(k) == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL deq_ch%0d: popped 0x%08h, expected no entry", k,
                                 bus.deq_data[k*DATA_W +: DATA_W]);
                    end else begin
                        chk($sformatf("deq_data_ch%0d", k), bus.deq_data[k*DATA_W +: DATA_W], qpop(k));
                    end
                end
            end
        end
    end

    // Driver tasks: each applies one cycle of inputs at the falling edge.
    task automatic cyc(input logic cs, input logic wr, input logic rd, input logic [3:0] addr,
                       input logic [31:0] wd, input logic [NUM_CH-1:0] rdy);
        @(negedge clk);
        bus.chipselect = cs;
        bus.write      = wr;
        bus.read       = rd;
        bus.address    = addr;
        bus.writedata  = wd;
        bus.deq_ready  = rdy;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, '0);
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] wd);
        cyc(1'b1, 1'b1, 1'b0, addr, wd, '0);
    endtask

    task automatic bus_read(input logic [3:0] addr, input logic [31:0] exp);
        rd_exp_q.push_back(exp);
        cyc(1'b1, 1'b0, 1'b1, addr, 32'd0, '0);
    endtask

    task automatic pop(input logic [NUM_CH-1:0] rdy);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, rdy);
    endtask

    initial begin
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.address    = 4'd0;
        bus.writedata  = 32'd0;
        bus.deq_ready  = '0;

        #1;
        chk("reset_deq_valid", 32'(bus.deq_valid), 32'd0);
        chk("reset_readdata", bus.readdata, 32'd0);
        idle();
        idle();
        @(negedge clk);
        reset = 1'b1;

        // Single write shows up at the head next cycle; occupancy reads 1.
        exp_push(0, 32'h0000_00A5);
        bus_write(4'd1, 32'h0000_00A5);
        bus_read(4'd1, 32'd1);
        #1;
        chk("a5_deq_valid", 32'(bus.deq_valid), 32'h1);
        chk("a5_deq_data", bus.deq_data[0 +: DATA_W], 32'h0000_00A5);
        pop(3'b001);
        idle();

        // Five writes to a DEPTH=4 channel: fifth is dropped.
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_push(1, 32'(i * 'h11));
            bus_write(4'd2, 32'(i * 'h11));
        end
        bus_read(4'd0, 32'h0002_0005);
        bus_read(4'd2, 32'd4);
        bus_read(4'd15, OVF_EXP);
        for (int i = 0; i < 5; i++) pop(3'b010);
        idle();
        #1;
        chk("drained_deq_valid", 32'(bus.deq_valid), 32'd0);

        // Full channel: push and pop on the same edge keeps occupancy at 4.
        for (int i = 1; i <= 4; i++) begin
            exp_push(2, 32'(i));
            bus_write(4'd3, 32'(i));
        end
        exp_push(2, 32'd5);
        cyc(1'b1, 1'b1, 1'b0, 4'd3, 32'd5, 3'b100);
        bus_read(4'd3, 32'd4);
        bus_read(4'd15, OVF_EXP);
        for (int i = 0; i < 4; i++) pop(3'b100);

        // Interleaved writes and pops across pointer wrap, values 1..10.
        for (int v = 1; v <= 10; v++) exp_push(0, 32'(v));
        bus_write(4'd1, 32'd1);
        bus_write(4'd1, 32'd2);
        for (int v = 3; v <= 10; v++) cyc(1'b1, 1'b1, 1'b0, 4'd1, 32'(v), 3'b001);
        bus_read(4'd1, 32'd2);
        pop(3'b001);
        pop(3'b001);
        idle();

        // Flush ch1 only; ch0 keeps its entry.
        exp_push(0, 32'd7);
        bus_write(4'd1, 32'd7);
        bus_write(4'd2, 32'd8);
        bus_write(4'd0, 32'h0000_0002);
        bus_read(4'd1, 32'd1);
        #1;
        chk("flush_deq_valid", 32'(bus.deq_valid), 32'h1);
        chk("flush_ch0_data", bus.deq_data[0 +: DATA_W], 32'd7);
        bus_read(4'd2, 32'd0);
        pop(3'b001);

        // Overflow clear, ignored writes, reserved reads, readdata hold.
        bus_write(4'd0, 32'h8000_0000);
        bus_read(4'd15, 32'd0);
        bus_write(4'd15, 32'h0000_1234);
        bus_write(4'd4, 32'h0000_0055);
        bus_read(4'd15, 32'd0);
        bus_read(4'd4, 32'd0);
        bus_read(4'd0, 32'h0000_0007);
        idle();
        idle();
        idle();
        #1;
        chk("readdata_hold", bus.readdata, 32'h0000_0007);

        // Asynchronous reset with entries queued and readdata non-zero.
        bus_write(4'd3, 32'd9);
        bus_write(4'd1, 32'd10);
        bus_read(4'd1, 32'd1);
        idle();
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst_deq_valid", 32'(bus.deq_valid), 32'd0);
        chk("async_rst_readdata", bus.readdata, 32'd0);
        ch0_q.delete();
        ch1_q.delete();
        ch2_q.delete();
        idle();
        @(negedge clk);
        reset = 1'b1;

        // Operation resumes with the old entries gone.
        exp_push(1, 32'h0000_003C);
        bus_write(4'd2, 32'h0000_003C);
        bus_read(4'd0, 32'h0000_0005);
        pop(3'b010);
        idle();
        idle();
        idle();

        chk("leftover_rd", 32'(rd_exp_q.size()), 32'd0);
        chk("leftover_ch0", 32'(ch0_q.size()), 32'd0);
        chk("leftover_ch1", 32'(ch1_q.size()), 32'd0);
        chk("leftover_ch2", 32'(ch2_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
